// File: rtl/alu_mul_seq_if.sv
// Bundle of request/response and shared-ALU signals for the multiply sequencer.
// Latency: none (wires only); ovf exists only when ALU_MUL_OVF_EN is defined.
// Backpressure: none; the requester must wait for done before relying on product.
interface alu_mul_seq_if #(
    parameter int SIZE = 9
);
    logic            start;
    logic [SIZE:0]   a;
    logic [SIZE:0]   b;
    logic            busy;
    logic            done;
    logic [SIZE:0]   product;
    logic [2:0]      alu_ctl;
    logic [SIZE:0]   alu_in1;
    logic [SIZE:0]   alu_in2;
    logic [SIZE:0]   alu_out;
    logic            alu_zero;
`ifdef ALU_MUL_OVF_EN
    logic            ovf;

    modport slave (
        input  start, a, b, alu_out, alu_zero,
        output busy, done, product, alu_ctl, alu_in1, alu_in2, ovf
    );
    modport master (
        output start, a, b, alu_out, alu_zero,
        input  busy, done, product, alu_ctl, alu_in1, alu_in2, ovf
    );
`else
    modport slave (
        input  start, a, b, alu_out, alu_zero,
        output busy, done, product, alu_ctl, alu_in1, alu_in2
    );
    modport master (
        output start, a, b, alu_out, alu_zero,
        input  busy, done, product, alu_ctl, alu_in1, alu_in2
    );
`endif
endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned shift-and-add multiplier that borrows the shared ALU; optional ovf via ALU_MUL_OVF_EN.
// Latency: 3 cycles per set multiplier bit, 2 per clear bit up to the top set bit, plus 1 DONE cycle.
// Backpressure: start is only accepted in IDLE; busy stays high through the DONE cycle.
module alu_mul_seq #(
    parameter int SIZE = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_mul_seq_if.slave  bus
);
    localparam int IW = $clog2(SIZE + 2);
    localparam logic [IW-1:0] ITER_LAST = IW'(SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHL,
        S_SHR,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [SIZE:0]   acc_q, acc_d;
    logic [SIZE:0]   mcand_q, mcand_d;
    logic [SIZE:0]   mplier_q, mplier_d;
    logic [IW-1:0]   iter_q, iter_d;
    logic [SIZE:0]   product_q, product_d;
`ifdef ALU_MUL_OVF_EN
    logic            lost_q, lost_d;
    logic            ovf_acc_q, ovf_acc_d;
    logic            ovf_q, ovf_d;
`endif

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.product = product_q;
`ifdef ALU_MUL_OVF_EN
    assign bus.ovf     = ovf_q;
`endif

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            iter_q    <= '0;
            product_q <= '0;
`ifdef ALU_MUL_OVF_EN
            lost_q    <= 1'b0;
            ovf_acc_q <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            iter_q    <= iter_d;
            product_q <= product_d;
`ifdef ALU_MUL_OVF_EN
            lost_q    <= lost_d;
            ovf_acc_q <= ovf_acc_d;
            ovf_q     <= ovf_d;
`endif
        end
    end

    // Next-state, register updates and ALU operand decode; all arithmetic is done by the ALU.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        iter_d      = iter_q;
        product_d   = product_q;
        bus.alu_ctl = 3'b111;
        bus.alu_in1 = '0;
        bus.alu_in2 = '0;
`ifdef ALU_MUL_OVF_EN
        lost_d      = lost_q;
        ovf_acc_d   = ovf_acc_q;
        ovf_d       = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    acc_d = '0;
`ifdef ALU_MUL_OVF_EN
                    lost_d    = 1'b0;
                    ovf_acc_d = 1'b0;
`endif
                    if (bus.b == '0) begin
                        // Nothing to accumulate: skip straight to DONE with a zero product.
                        state_d = S_DONE;
                    end else begin
                        mcand_d  = bus.a;
                        mplier_d = bus.b;
                        iter_d   = '0;
                        state_d  = bus.b[0] ? S_ADD : S_SHL;
                    end
                end
            end
            S_ADD: begin
                bus.alu_ctl = 3'b001;
                bus.alu_in1 = acc_q;
                bus.alu_in2 = mcand_q;
                acc_d       = bus.alu_out;
`ifdef ALU_MUL_OVF_EN
                // A wrapped sum, or adding a multiplicand that already shed high bits, overflows.
                if ((bus.alu_out < acc_q) || lost_q) begin
                    ovf_acc_d = 1'b1;
                end
`endif
                state_d     = S_SHL;
            end
            S_SHL: begin
                bus.alu_ctl = 3'b100;
                bus.alu_in1 = mcand_q;
                mcand_d     = bus.alu_out;
`ifdef ALU_MUL_OVF_EN
                if (mcand_q[SIZE]) begin
                    lost_d = 1'b1;
                end
`endif
                state_d     = S_SHR;
            end
            S_SHR: begin
                bus.alu_ctl = 3'b110;
                bus.alu_in1 = mplier_q;
                mplier_d    = bus.alu_out;
                iter_d      = iter_q + IW'(1);
                // Stop as soon as no set multiplier bits remain, or after the last bit position.
                if (bus.alu_zero || (iter_q == ITER_LAST)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = bus.alu_out[0] ? S_ADD : S_SHL;
                end
            end
            S_DONE: begin
                product_d = acc_q;
`ifdef ALU_MUL_OVF_EN
                ovf_d     = ovf_acc_q;
`endif
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_alu_mul_seq.sv
// Randomized and directed bench for alu_mul_seq with a behavioural ALU and arithmetic reference model.
// Latency: each operation is tracked cycle by cycle from the start edge to done.
// Backpressure: start re-pulses while busy are expected to be ignored.
module tb_alu_mul_seq;
    localparam int SIZE = 9;
    localparam int W    = SIZE + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    logic [W-1:0] alu_res;
    logic [2:0]   ctl_seen [$];

    always #5 clk = ~clk;

    alu_mul_seq_if #(.SIZE(SIZE)) ifc ();

    alu_mul_seq #(.SIZE(SIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    // Behavioural shared ALU: combinational, wraps to W bits.
    always_comb begin
        alu_res = '0;
        case (ifc.alu_ctl)
            3'b001:  alu_res = ifc.alu_in1 + ifc.alu_in2;
            3'b100:  alu_res = ifc.alu_in1 << 1;
            3'b110:  alu_res = ifc.alu_in1 >> 1;
            default: alu_res = '0;
        endcase
    end
    assign ifc.alu_out  = alu_res;
    assign ifc.alu_zero = (alu_res == '0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Cycles from the start edge to the DONE cycle, from the bit-cost rule.
    function automatic int ref_lat(input logic [W-1:0] bv);
        int h = 0;
        int c = 1;
        if (bv == '0) return 1;
        for (int i = 0; i < W; i++) if (bv[i]) h = i;
        for (int i = 0; i <= h; i++) c += bv[i] ? 3 : 2;
        return c;
    endfunction

    // Expected ALU opcode stream for a nonzero multiplier, followed by the idle DONE cycle.
    task automatic check_seq(input logic [W-1:0] bv);
        logic [2:0] exp_q [$];
        int h = 0;
        for (int i = 0; i < W; i++) if (bv[i]) h = i;
        for (int i = 0; i <= h; i++) begin
            if (bv[i]) exp_q.push_back(3'b001);
            exp_q.push_back(3'b100);
            exp_q.push_back(3'b110);
        end
        exp_q.push_back(3'b111);
        chk("ctl_len", ctl_seen.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < ctl_seen.size(); i++)
            chk($sformatf("ctl[%0d]", i), {29'd0, ctl_seen[i]}, {29'd0, exp_q[i]});
    endtask

    // Called at a negedge; issues one multiply and returns at the negedge after done.
    task automatic run_mul(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                           input int re_cyc, input logic [W-1:0] ra, input logic [W-1:0] rb,
                           input int rst_cyc);
        int lat = ref_lat(tbv);
        int done_cyc = 0;
        int busy_cnt = 0;
        int act_cnt  = 0;
        logic [31:0] full = 32'(ta) * 32'(tbv);
        ctl_seen.delete();
        ifc.start = 1'b1;
        ifc.a     = ta;
        ifc.b     = tbv;
        @(posedge clk);
        for (int n = 1; n <= 60 && done_cyc == 0; n++) begin
            @(negedge clk);
            if (n == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                chk("rst_busy", {31'd0, ifc.busy}, 0);
                chk("rst_done", {31'd0, ifc.done}, 0);
                chk("rst_product", 32'(ifc.product), 0);
                chk("rst_ctl", 32'(ifc.alu_ctl), 7);
                chk("rst_in1", 32'(ifc.alu_in1), 0);
                chk("rst_in2", 32'(ifc.alu_in2), 0);
`ifdef ALU_MUL_OVF_EN
                chk("rst_ovf", {31'd0, ifc.ovf}, 0);
`endif
                ifc.start = 1'b0;
                @(negedge clk);
                chk("rst_hold_done", {31'd0, ifc.done}, 0);
                rst_n = 1'b1;
                return;
            end
            ctl_seen.push_back(ifc.alu_ctl);
            if (ifc.busy) busy_cnt++;
            if (ifc.alu_ctl != 3'b111) act_cnt++;
            if (ifc.done) done_cyc = n;
            if (n == re_cyc) begin
                ifc.start = 1'b1;
                ifc.a     = ra;
                ifc.b     = rb;
            end else begin
                ifc.start = 1'b0;
                ifc.a     = W'($urandom);
                ifc.b     = W'($urandom);
            end
        end
        @(negedge clk);
        ifc.start = 1'b0;
        chk("done_cycle", done_cyc, lat);
        chk("busy_cycles", busy_cnt, lat);
        chk("alu_active", act_cnt, lat - 1);
        chk("idle_busy", {31'd0, ifc.busy}, 0);
        chk("idle_done", {31'd0, ifc.done}, 0);
        chk($sformatf("product %0d*%0d", ta, tbv), 32'(ifc.product), {22'd0, full[W-1:0]});
`ifdef ALU_MUL_OVF_EN
        chk($sformatf("ovf %0d*%0d", ta, tbv), {31'd0, ifc.ovf}, {31'd0, |full[31:W]});
`endif
    endtask

    initial begin
        logic [W-1:0] ra, rb, msk;
        // Reset with arbitrary inputs.
        ifc.start = 1'b1;
        ifc.a     = W'($urandom);
        ifc.b     = W'($urandom);
        #1;
        chk("reset_busy", {31'd0, ifc.busy}, 0);
        chk("reset_done", {31'd0, ifc.done}, 0);
        chk("reset_product", 32'(ifc.product), 0);
        chk("reset_ctl", 32'(ifc.alu_ctl), 7);
        ifc.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_mul(10'd3, 10'd5, 0, 10'd0, 10'd0, 0);
        check_seq(10'd5);
        run_mul(10'd7, 10'd0, 0, 10'd0, 10'd0, 0);
        run_mul(10'd1023, 10'd1023, 0, 10'd0, 10'd0, 0);
        run_mul(10'd31, 10'd33, 0, 10'd0, 10'd0, 0);
        check_seq(10'd33);
        run_mul(10'd0, 10'd77, 0, 10'd0, 10'd0, 0);
        // Re-pulse while busy is ignored; next start back-to-back after done.
        run_mul(10'd3, 10'd5, 4, 10'd9, 10'd9, 0);
        run_mul(10'd6, 10'd7, 0, 10'd0, 10'd0, 0);
        // Start during the DONE cycle is ignored.
        run_mul(10'd31, 10'd33, ref_lat(10'd33), 10'd2, 10'd2, 0);
        // Reset mid-operation, then a clean run.
        run_mul(10'd3, 10'd5, 0, 10'd0, 10'd0, 5);
        run_mul(10'd3, 10'd5, 0, 10'd0, 10'd0, 0);

        for (int k = 0; k < 40; k++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0: rb = W'($urandom);
                1: rb = W'($urandom_range(0, 7));
                2: rb = '0;
                default: begin
                    msk = '1;
                    msk = msk >> $urandom_range(0, W - 1);
                    rb  = msk;
                end
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_mul(ra, rb, $urandom_range(0, ref_lat(rb)), W'($urandom), W'($urandom), 0);
            if (k % 8 == 0 && rb != '0) check_seq(rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
Multi-cycle unsigned multiply sequencer that borrows the shared 3-bit-ctl ALU to compute a shift-and-add product.
- Drives ALU ctl/in1/in2 and reads ALU out/zero; it contains no adder or shifter of its own.
- Sits beside the EX stage. The hazard unit holds the pipeline while busy=1, so the ALU is free for the sequencer.
- Product is truncated to the datapath width (SIZE+1 bits).

Parameters:
SIZE, 9, MSB index of datapath words; word width is SIZE+1 (matches ALU SIZE).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
a  in  SIZE+1  multiplicand, unsigned; latched when start accepted
b  in  SIZE+1  multiplier, unsigned; latched when start accepted
busy  out  1  high from the cycle after start accepted through the DONE cycle
done  out  1  one-cycle pulse in the DONE state
product  out  SIZE+1  (a*b) mod 2^(SIZE+1); held until next accepted start
alu_ctl  out  3  ALU opcode: 001 add, 100 shift-left-1, 110 shift-right-1, 111 idle
alu_in1  out  SIZE+1  ALU operand 1
alu_in2  out  SIZE+1  ALU operand 2
alu_out  in  SIZE+1  ALU result, combinational, same cycle
alu_zero  in  1  ALU zero flag, same cycle

Behaviour:
Reset (async, rst_n=0):
- State IDLE; acc, mcand, mplier, iter counter, product cleared to 0.
- busy=0, done=0.
- ALU drive: alu_ctl=111, alu_in1=0, alu_in2=0.

Registers:
- acc, mcand, mplier: SIZE+1 bits each.
- iter: counter wide enough to hold SIZE+1.

ALU outputs are a combinational decode of state:
- ADD: ctl=001, in1=acc, in2=mcand.
- SHL: ctl=100, in1=mcand, in2=0.
- SHR: ctl=110, in1=mplier, in2=0.
- IDLE/DONE: ctl=111, in1=0, in2=0.

State transitions:
- IDLE:
  - start=1 and b==0: acc<=0, go DONE.
  - start=1 and b!=0: mcand<=a, mplier<=b, acc<=0, iter<=0. Go ADD if b[0] else SHL.
  - start=0: stay.
- ADD: acc<=alu_out; go SHL.
- SHL: mcand<=alu_out; go SHR.
- SHR: mplier<=alu_out, iter<=iter+1.
  - If alu_zero=1 or iter==SIZE: go DONE.
  - Otherwise go ADD if alu_out[0] else SHL.
- DONE: done=1, product<=acc; go IDLE.

Latency:
- Each multiplier bit up to and including the highest set bit costs 3 cycles if 1, 2 cycles if 0.
- Followed by 1 DONE cycle.
- Worst case (b all ones) is 3*(SIZE+1)+1 cycles after start is sampled.

Boundary and simultaneous conditions:
- start while not IDLE: ignored; no re-latch of a/b.
- start in the DONE cycle: ignored.
- A start on the cycle after done is accepted.
- a or b changing after acceptance: no effect.
- b==0: early exit, product=0. a==0: normal iteration, product=0.
- Truncation: the ALU wraps silently; product is the low SIZE+1 bits.
- rst_n low mid-operation: immediate abort to the reset values above. No done pulse; product is cleared.

Optional Feature:
Macro ALU_MUL_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0).
  - Sticky internal bit lost is set in SHL when mcand[SIZE]=1, and cleared on start.
  - ovf_acc is set in ADD when alu_out < acc (unsigned wrap) or lost=1.
  - ovf is loaded from ovf_acc in DONE and held alongside product.
- Not defined: no ovf port; no lost/ovf_acc registers.

Test Plan:
- Reset: rst_n=0 with arbitrary inputs -> busy=0, done=0, product=0, alu_ctl=111.
- a=3, b=5, start one cycle:
  - ALU ctl sequence is 001,100,110,100,110,001,100,110.
  - done pulses 9 cycles after start; product=15; busy high for cycles 1..9.
- a=7, b=0:
  - done pulses 1 cycle after start; product=0.
  - ALU ctl never leaves 111.
- a=1023, b=1023 (SIZE=9):
  - done pulses 31 cycles after start; product=1.
  - ovf=1 with ALU_MUL_OVF_EN.
  - a=31, b=33 gives product=1023, ovf=0.
- a=3, b=5 started; start re-pulsed with a=9, b=9 in cycle 4 -> ignored, product=15.
  - Then a=6, b=7 started the cycle after done -> product=42.
- a=3, b=5 started; rst_n pulsed low in cycle 5 -> outputs return to reset values immediately, no done pulse.
  - A new start after reset yields correct product=15.
